// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO controller.
// Default geometry is a 16-bit x 32-word FIFO.
package fifo_pkg;

   localparam int DEF_DATA = 16;
   localparam int DEF_ADDR = 5;
   localparam int DEPTH    = 2**DEF_ADDR;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int ptr_width(input int addr);
      return addr + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit binary pointer: an incrementing register that rolls over naturally.
// The top instantiates one pointer for writes and one for reads.
module fifo_ptr #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // Advance by one on each accepted operation; the modulo wrap comes free from the width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (inc) begin
         // NOTE: non-blocking, so both pointers update together from the pre-edge state.
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FWFT FIFO controller driving an external dual-port RAM.
// Port A of the RAM takes writes; port B is read combinationally for the head word.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags;
// without it, both flags are tied low and no flag registers exist.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA     = DEF_DATA,
   parameter int ADDR     = DEF_ADDR,
   parameter int AFULL_TH = 2**ADDR - 2
) (
   input  logic            clK,
   input  logic            rst_n,
   input  logic            wr_EN,
   input  logic [DATA-1:0] wr_DATA,
   input  logic            rd_EN,
   output logic [DATA-1:0] rd_DATA,
   output logic            full,
   output logic            empty,
   output logic            almost_full,
   output logic [ADDR:0]   count,
   output logic            overflow,
   output logic            underflow,
   output logic            mem_a_WR,
   output logic [ADDR-1:0] mem_a_ADDR,
   output logic [DATA-1:0] mem_a_DATA,
   output logic            mem_b_WR,
   output logic [ADDR-1:0] mem_b_ADDR,
   input  logic [DATA-1:0] mem_b_DATA
);

   localparam int PW = ptr_width(ADDR);
   localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_TH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_acc;
   logic          rd_acc;

   // Acceptance uses the current (pre-edge) flags: a full FIFO drops writes, an empty one ignores reads.
   assign wr_acc = wr_EN & ~full;
   assign rd_acc = rd_EN & ~empty;

   fifo_ptr #(.W(PW)) u_wr_ptr (
      .clk   (clK),
      .rst_n (rst_n),
      .inc   (wr_acc),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(.W(PW)) u_rd_ptr (
      .clk   (clK),
      .rst_n (rst_n),
      .inc   (rd_acc),
      .ptr   (rd_ptr)
   );

   // Occupancy and flags all fall out of the two wrap-bit pointers.
   assign count       = wr_ptr - rd_ptr;
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[ADDR] != rd_ptr[ADDR]) &&
                        (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]);
   assign almost_full = (count >= AFULL_CNT);

   // NOTE: the RAM itself is never cleared on reset; the pointers alone decide which words are valid.
   assign mem_a_WR   = wr_acc;
   assign mem_a_ADDR = wr_ptr[ADDR-1:0];
   assign mem_a_DATA = wr_DATA;
   assign mem_b_WR   = 1'b0;
   assign mem_b_ADDR = rd_ptr[ADDR-1:0];
   assign rd_DATA    = mem_b_DATA;

`ifdef FIFO_ERR_FLAGS_EN
   // Sticky error flags: set on a write attempted while full or a read attempted while empty; cleared only by reset.
   always_ff @(posedge clK or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_EN && full)  overflow  <= 1'b1;
         if (rd_EN && empty) underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model. Includes a simple RAM model.
module tb_fifo_ctrl;
   import fifo_pkg::*;

   localparam int DW = DEF_DATA;
   localparam int AW = DEF_ADDR;
   localparam int AFULL = DEPTH - 2;
`ifdef FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clK = 1'b0;
   logic          rst_n;
   logic          wr_EN;
   logic [DW-1:0] wr_DATA;
   logic          rd_EN;
   logic [DW-1:0] rd_DATA;
   logic          full, empty, almost_full;
   logic [AW:0]   count;
   logic          overflow, underflow;
   logic          mem_a_WR, mem_b_WR;
   logic [AW-1:0] mem_a_ADDR, mem_b_ADDR;
   logic [DW-1:0] mem_a_DATA, mem_b_DATA;

   int total = 0;
   int bad   = 0;

   fifo_ctrl dut (
      .clK         (clK),
      .rst_n       (rst_n),
      .wr_EN       (wr_EN),
      .wr_DATA     (wr_DATA),
      .rd_EN       (rd_EN),
      .rd_DATA     (rd_DATA),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow),
      .mem_a_WR    (mem_a_WR),
      .mem_a_ADDR  (mem_a_ADDR),
      .mem_a_DATA  (mem_a_DATA),
      .mem_b_WR    (mem_b_WR),
      .mem_b_ADDR  (mem_b_ADDR),
      .mem_b_DATA  (mem_b_DATA)
   );

   always #5 clK = ~clK;

   // External dual-port RAM: synchronous write on port A, combinational read on port B.
   logic [DW-1:0] ram [0:DEPTH-1];
   initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
   always @(posedge clK) if (mem_a_WR) ram[mem_a_ADDR] <= mem_a_DATA;
   assign mem_b_DATA = ram[mem_b_ADDR];

   // Reference model: a queue of stored words plus running write/read addresses.
   logic [DW-1:0] q[$];
   int  m_waddr = 0;
   int  m_raddr = 0;
   bit  m_ov = 0;
   bit  m_un = 0;

   always @(posedge clK or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_waddr = 0;
         m_raddr = 0;
         m_ov = 0;
         m_un = 0;
      end else begin
         automatic bit wa = wr_EN && (q.size() < DEPTH);
         automatic bit ra = rd_EN && (q.size() > 0);
         if (wr_EN && q.size() == DEPTH) m_ov = 1;
         if (rd_EN && q.size() == 0)     m_un = 1;
         if (ra) begin
            void'(q.pop_front());
            m_raddr = (m_raddr + 1) % DEPTH;
         end
         if (wa) begin
            q.push_back(wr_DATA);
            m_waddr = (m_waddr + 1) % DEPTH;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Cycle-by-cycle compare of every DUT output against the model, on the falling edge.
   always @(negedge clK) begin
      automatic int sz = q.size();
      check("count",       32'(count),       32'(sz));
      check("empty",       32'(empty),       32'(sz == 0));
      check("full",        32'(full),        32'(sz == DEPTH));
      check("almost_full", 32'(almost_full), 32'(sz >= AFULL));
      check("overflow",    32'(overflow),    32'(ERR_EN && m_ov));
      check("underflow",   32'(underflow),   32'(ERR_EN && m_un));
      check("mem_a_WR",    32'(mem_a_WR),    32'(wr_EN && sz < DEPTH));
      check("mem_a_ADDR",  32'(mem_a_ADDR),  32'(m_waddr));
      check("mem_a_DATA",  32'(mem_a_DATA),  32'(wr_DATA));
      check("mem_b_WR",    32'(mem_b_WR),    32'(0));
      check("mem_b_ADDR",  32'(mem_b_ADDR),  32'(m_raddr));
      if (sz > 0) check("rd_DATA", 32'(rd_DATA), 32'(q[0]));
   end

   task automatic tick;
      @(posedge clK);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      wr_EN = 1'b0;
      rd_EN = 1'b0;
      wr_DATA = '0;
      #22 rst_n = 1'b1;
      tick();
      tick();
      check("rst_empty", 32'(empty), 32'(1));
      check("rst_count", 32'(count), 32'(0));
      check("rst_full",  32'(full),  32'(0));
      check("rst_memwr", 32'(mem_a_WR), 32'(0));

      // Fill with 1..32, watching almost_full cross at 30.
      for (int i = 1; i <= DEPTH; i++) begin
         wr_EN = 1'b1;
         wr_DATA = DW'(i);
         tick();
         if (i == AFULL - 1) check("af_below", 32'(almost_full), 32'(0));
         if (i == AFULL)     check("af_at",    32'(almost_full), 32'(1));
      end
      check("fill_full",  32'(full),  32'(1));
      check("fill_count", 32'(count), 32'(32));
      wr_DATA = 16'h0021;
      tick();
      wr_EN = 1'b0;
      check("drop_count", 32'(count), 32'(32));
      check("ovf_lit",    32'(overflow), 32'(ERR_EN));

      // Drain, expecting 1..32 in order.
      for (int i = 1; i <= DEPTH; i++) begin
         check("drain_data", 32'(rd_DATA), 32'(i));
         rd_EN = 1'b1;
         tick();
      end
      check("drain_empty", 32'(empty), 32'(1));
      tick();
      rd_EN = 1'b0;
      check("under_count", 32'(count), 32'(0));
      check("unf_lit",     32'(underflow), 32'(ERR_EN));

      // Steady state at count=5 with simultaneous push/pop for 100 cycles.
      for (int i = 0; i < 5; i++) begin
         wr_EN = 1'b1;
         wr_DATA = DW'(16'h0100 + i);
         tick();
      end
      rd_EN = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wr_DATA = DW'(16'h0200 + i);
         tick();
      end
      wr_EN = 1'b0;
      check("steady_count", 32'(count), 32'(5));
      check("steady_head",  32'(rd_DATA), 32'(16'h0200 + 95));
      for (int i = 0; i < 5; i++) tick();
      rd_EN = 1'b0;

      // Simultaneous push/pop on an empty FIFO: only the write lands.
      wr_EN = 1'b1;
      rd_EN = 1'b1;
      wr_DATA = 16'hA5A5;
      tick();
      wr_EN = 1'b0;
      rd_EN = 1'b0;
      check("empty_both_count", 32'(count), 32'(1));
      check("empty_both_data",  32'(rd_DATA), 32'(16'hA5A5));

      // Top up to full, then simultaneous push/pop: only the read lands.
      wr_EN = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
         wr_DATA = DW'(16'h0300 + i);
         tick();
      end
      check("topup_full", 32'(full), 32'(1));
      rd_EN = 1'b1;
      wr_DATA = 16'hDEAD;
      tick();
      wr_EN = 1'b0;
      rd_EN = 1'b0;
      check("full_both_count", 32'(count), 32'(31));
      check("full_both_head",  32'(rd_DATA), 32'(16'h0300));

      // Drain, refill to 12, then reset asynchronously mid-burst.
      rd_EN = 1'b1;
      for (int i = 0; i < DEPTH; i++) tick();
      rd_EN = 1'b0;
      wr_EN = 1'b1;
      for (int i = 0; i < 12; i++) begin
         wr_DATA = DW'(16'h0400 + i);
         tick();
      end
      check("pre_rst_count", 32'(count), 32'(12));
      #2;
      rst_n = 1'b0;
      wr_EN = 1'b0;
      #1;
      check("async_empty", 32'(empty), 32'(1));
      check("async_count", 32'(count), 32'(0));
      #2 rst_n = 1'b1;
      tick();
      wr_EN = 1'b1;
      wr_DATA = 16'hBEEF;
      tick();
      wr_EN = 1'b0;
      check("beef_data",  32'(rd_DATA), 32'(16'hBEEF));
      check("beef_count", 32'(count), 32'(1));

      // Randomized traffic, write-biased then read-biased, to sweep full/empty repeatedly.
      for (int i = 0; i < 600; i++) begin
         automatic int wthr = ((i / 75) % 2 == 0) ? 75 : 35;
         wr_EN   = ($urandom_range(0, 99) < wthr);
         rd_EN   = ($urandom_range(0, 99) < (110 - wthr));
         wr_DATA = DW'($urandom);
         tick();
      end
      wr_EN = 1'b0;
      rd_EN = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Single-clock synchronous FIFO controller that sits directly upstream of the dual-port RAM and drives its address and write-enable pins.
- Port A of the RAM is used for writes only; port B is used for reads only.
- Owns the read/write pointers, occupancy count, full/empty/almost-full flags and optional error flags.
- Presents first-word-fall-through (FWFT) read data taken straight from the RAM's combinational port-B output.

Parameters:
- DATA, 16, word width; must match the RAM's DATA.
- ADDR, 5, RAM address width; depth = 2**ADDR.
- AFULL_TH, 2**ADDR-2, count at or above which almost_full asserts.

Ports:
- clK  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_EN  in  1  write request.
- wr_DATA  in  DATA  write word.
- rd_EN  in  1  read/pop request.
- rd_DATA  out  DATA  head-of-FIFO word, FWFT; valid while empty=0.
- full  out  1  FIFO holds 2**ADDR words.
- empty  out  1  FIFO holds 0 words.
- almost_full  out  1  count >= AFULL_TH.
- count  out  ADDR+1  current occupancy, 0..2**ADDR.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- mem_a_WR  out  1  to RAM a_port_WR.
- mem_a_ADDR  out  ADDR  to RAM a_port_ADDR.
- mem_a_DATA  out  DATA  to RAM a_port_data_IN.
- mem_b_WR  out  1  to RAM b_port_WR; tied 0.
- mem_b_ADDR  out  ADDR  to RAM b_port_ADDR.
- mem_b_DATA  in  DATA  from RAM b_port_data_OUT.

Behaviour:
- Reset: rst_n=0 asynchronously clears wr_ptr, rd_ptr and the sticky flags. Outputs go to empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0, mem_a_WR=0. RAM contents are not cleared; reset mid-operation discards all stored words.
- Pointers: wr_ptr and rd_ptr are ADDR+1 bits wide. The low ADDR bits address the RAM; the MSB is the wrap bit. Each pointer increments modulo 2**(ADDR+1) on an accepted operation.
- Accept rules: wr_acc = wr_EN & ~full; rd_acc = rd_EN & ~empty. Both evaluate on the pre-edge state.
- Simultaneous write and read:
  - When full, only the read is accepted; the write is dropped.
  - When empty, only the write is accepted.
  - Otherwise both are accepted and count is unchanged.
- RAM drive (combinational from registered state):
  - mem_a_WR = wr_acc; mem_a_ADDR = wr_ptr[ADDR-1:0]; mem_a_DATA = wr_DATA.
  - mem_b_ADDR = rd_ptr[ADDR-1:0]; rd_DATA = mem_b_DATA.
- Latency: a word written at edge N is visible on rd_DATA, with empty=0, after edge N. Write-to-read latency is 1 cycle. A pop at edge N presents the next word after edge N.
- Flag and count derivation:
  - count = wr_ptr - rd_ptr, ADDR+1 bits.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low ADDR bits are equal.
  - almost_full = (count >= AFULL_TH).
- Wrap-around: after 2**ADDR writes, addresses restart at 0 and the MSB toggles. Full/empty stay correct across any number of wraps.
- rd_DATA while empty is don't-care; the bench must not check it.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- Defined: overflow sets on the edge where wr_EN & full, and underflow sets on the edge where rd_EN & empty. Both hold until rst_n.
- Undefined: overflow and underflow are tied 0 and no flag registers are synthesised.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA/ADDR constants;
  - a ptr-width function (ADDR+1);
  - the localparam DEPTH = 2**ADDR.
- Natural sub-module fifo_ptr: a wrap-bit pointer register with increment enable, async active-low reset and a binary output. It is instantiated twice, once for write and once for read.
- The RAM itself stays external and is connected at the next level up.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, mem_a_WR=0; no pointer movement.
- Write 0x0001..0x0020 (32 words, ADDR=5) -> full=1 after the 32nd edge, count=32, almost_full=1 from count=30. A 33rd write is dropped and overflow=1 with the macro defined.
- Drain all 32 words -> rd_DATA sequence 0x0001..0x0020 in order; empty=1 after the last pop. A further rd_EN leaves count=0 and sets underflow=1 with the macro defined.
- Simultaneous wr_EN/rd_EN at count=5 for 100 cycles -> count stays 5, pointers wrap at least 3 times, and data order is preserved.
- Simultaneous wr_EN/rd_EN when empty -> write accepted, count=1, rd_DATA = written word next cycle. When full -> read only, count=31.
- Assert rst_n=0 mid-burst at count=12 -> empty=1 and count=0 immediately (asynchronous). After release, a new write of 0xBEEF reads back 0xBEEF.
